// File: rtl/csr_wb_sequencer.sv
// Serialises one CSR writeback request (read, then up to two writes) onto a single-port CSR file.
// Latency: o_valid 2/3/4 cycles after the request cycle for 0/1/2 writes; o_ready only in IDLE, response held until i_ready.
// Optional CSR_WR_MERGE_EN: same-address write pair collapses to the port-2 write only.
module csr_wb_sequencer #(
    parameter int AW = 12,
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [AW-1:0] i_raddr,
    input  logic [DW-1:0] i_wdata1,
    input  logic [AW-1:0] i_waddr1,
    input  logic          i_wena1,
    input  logic [DW-1:0] i_wdata2,
    input  logic [AW-1:0] i_waddr2,
    input  logic          i_wena2,
    output logic [AW-1:0] o_csr_raddr,
    input  logic [DW-1:0] i_csr_rdata,
    output logic [AW-1:0] o_csr_waddr,
    output logic [DW-1:0] o_csr_wdata,
    output logic          o_csr_wen,
    output logic          o_valid,
    output logic [DW-1:0] o_rdata,
    input  logic          i_ready
);

    typedef enum logic [2:0] {IDLE, RD, WR1, WR2, RESP} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic [AW-1:0] waddr1_q, waddr1_d, waddr2_q, waddr2_d;
    logic [DW-1:0] wdata1_q, wdata1_d, wdata2_q, wdata2_d;
    logic          wena1_q, wena1_d, wena2_q, wena2_d;

    logic          ready_q, valid_q, wen_q;
    logic [AW-1:0] csr_raddr_q, csr_waddr_q;
    logic [DW-1:0] csr_wdata_q, rdata_q;

    always_comb begin
        state_d  = state_q;
        raddr_d  = raddr_q;
        waddr1_d = waddr1_q;
        wdata1_d = wdata1_q;
        wena1_d  = wena1_q;
        waddr2_d = waddr2_q;
        wdata2_d = wdata2_q;
        wena2_d  = wena2_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    raddr_d  = i_raddr;
                    waddr1_d = i_waddr1;
                    wdata1_d = i_wdata1;
                    wena1_d  = i_wena1;
                    waddr2_d = i_waddr2;
                    wdata2_d = i_wdata2;
                    wena2_d  = i_wena2;
                    state_d  = RD;
                end
            end
            RD: begin
                if (wena1_q) begin
`ifdef CSR_WR_MERGE_EN
                    // port 2 overwrites port 1 anyway, so the first write is redundant
                    if (wena2_q && (waddr1_q == waddr2_q)) state_d = WR2;
                    else                                   state_d = WR1;
`else
                    state_d = WR1;
`endif
                end else if (wena2_q) begin
                    state_d = WR2;
                end else begin
                    state_d = RESP;
                end
            end
            WR1:     state_d = wena2_q ? WR2 : RESP;
            WR2:     state_d = RESP;
            RESP:    if (i_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            raddr_q     <= '0;
            waddr1_q    <= '0;
            wdata1_q    <= '0;
            wena1_q     <= 1'b0;
            waddr2_q    <= '0;
            wdata2_q    <= '0;
            wena2_q     <= 1'b0;
            ready_q     <= 1'b1;
            valid_q     <= 1'b0;
            wen_q       <= 1'b0;
            csr_raddr_q <= '0;
            csr_waddr_q <= '0;
            csr_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            raddr_q     <= raddr_d;
            waddr1_q    <= waddr1_d;
            wdata1_q    <= wdata1_d;
            wena1_q     <= wena1_d;
            waddr2_q    <= waddr2_d;
            wdata2_q    <= wdata2_d;
            wena2_q     <= wena2_d;
            ready_q     <= (state_d == IDLE);
            valid_q     <= (state_d == RESP);
            wen_q       <= (state_d == WR1) || (state_d == WR2);
            csr_raddr_q <= (state_d == IDLE) ? '0 : raddr_d;
            csr_waddr_q <= (state_d == WR1) ? waddr1_d :
                           (state_d == WR2) ? waddr2_d : '0;
            csr_wdata_q <= (state_d == WR1) ? wdata1_d :
                           (state_d == WR2) ? wdata2_d : '0;
            if (state_q == RD) rdata_q <= i_csr_rdata;
        end
    end

    assign o_ready     = ready_q;
    assign o_valid     = valid_q;
    assign o_csr_wen   = wen_q;
    assign o_csr_raddr = csr_raddr_q;
    assign o_csr_waddr = csr_waddr_q;
    assign o_csr_wdata = csr_wdata_q;
    assign o_rdata     = rdata_q;

endmodule

// File: tb/tb_csr_wb_sequencer.sv
// Bench for csr_wb_sequencer: directed and randomised requests against a transaction-level CSR file model.
module tb_csr_wb_sequencer;

`ifdef CSR_WR_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst, i_valid, o_ready;
    logic [11:0] i_raddr, i_waddr1, i_waddr2, o_csr_raddr, o_csr_waddr;
    logic [31:0] i_wdata1, i_wdata2, i_csr_rdata, o_csr_wdata, o_rdata;
    logic        i_wena1, i_wena2, o_csr_wen, o_valid, i_ready;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem     [0:4095];
    logic [31:0] ref_mem [0:4095];
    logic [43:0] mon_q[$];
    logic [11:0] pick [0:3];

    always #5 i_clk = ~i_clk;

    csr_wb_sequencer #(.AW(12), .DW(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_raddr(i_raddr), .i_wdata1(i_wdata1), .i_waddr1(i_waddr1), .i_wena1(i_wena1),
        .i_wdata2(i_wdata2), .i_waddr2(i_waddr2), .i_wena2(i_wena2),
        .o_csr_raddr(o_csr_raddr), .i_csr_rdata(i_csr_rdata),
        .o_csr_waddr(o_csr_waddr), .o_csr_wdata(o_csr_wdata), .o_csr_wen(o_csr_wen),
        .o_valid(o_valid), .o_rdata(o_rdata), .i_ready(i_ready)
    );

    // CSR file environment: combinational read, write on the clock edge
    assign i_csr_rdata = mem[o_csr_raddr];
    always @(posedge i_clk) if (o_csr_wen) mem[o_csr_waddr] <= o_csr_wdata;
    always @(negedge i_clk) if (o_csr_wen) mon_q.push_back({o_csr_waddr, o_csr_wdata});

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic scramble();
        i_raddr  = 12'($urandom);
        i_waddr1 = 12'($urandom);
        i_waddr2 = 12'($urandom);
        i_wdata1 = $urandom;
        i_wdata2 = $urandom;
        i_wena1  = 1'($urandom);
        i_wena2  = 1'($urandom);
    endtask

    task automatic txn(input logic [11:0] ra, input logic w1e, input logic [11:0] wa1,
                       input logic [31:0] wd1, input logic w2e, input logic [11:0] wa2,
                       input logic [31:0] wd2, input int bp);
        logic [43:0] exp_q[$];
        logic [31:0] exp_rdata;
        int          lat, exp_lat;
        exp_rdata = ref_mem[ra];
        if (w1e && !(MERGE && w2e && wa1 == wa2)) exp_q.push_back({wa1, wd1});
        if (w2e) exp_q.push_back({wa2, wd2});
        if (w1e) ref_mem[wa1] = wd1;
        if (w2e) ref_mem[wa2] = wd2;
        exp_lat = 2 + exp_q.size();
        mon_q.delete();
        chk("ready_before_req", 64'(o_ready), 64'd1);
        i_raddr = ra; i_wena1 = w1e; i_waddr1 = wa1; i_wdata1 = wd1;
        i_wena2 = w2e; i_waddr2 = wa2; i_wdata2 = wd2; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        scramble();
        lat = 1;
        while (!o_valid && lat < 20) begin
            chk("ready_low_busy", 64'(o_ready), 64'd0);
            tick();
            lat++;
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("rdata", 64'(o_rdata), 64'(exp_rdata));
        chk("wen_pulses", 64'(mon_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < mon_q.size(); k++)
            chk("wen_addr_data", 64'(mon_q[k]), 64'(exp_q[k]));
        for (int k = 0; k < bp; k++) begin
            i_valid = 1'b1;
            scramble();
            tick();
            chk("bp_valid", 64'(o_valid), 64'd1);
            chk("bp_rdata", 64'(o_rdata), 64'(exp_rdata));
            chk("bp_ready", 64'(o_ready), 64'd0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk("post_hs_valid", 64'(o_valid), 64'd0);
        chk("post_hs_ready", 64'(o_ready), 64'd1);
        chk("no_stray_wen", 64'(mon_q.size()), 64'(exp_q.size()));
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) begin
            mem[a] = $urandom;
            ref_mem[a] = mem[a];
        end
        pick[0] = 12'h300; pick[1] = 12'h305; pick[2] = 12'h341; pick[3] = 12'h342;
        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
        scramble();
        tick(); tick();
        i_rst = 1'b0;
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_wen", 64'(o_csr_wen), 64'd0);
        chk("rst_rdata", 64'(o_rdata), 64'd0);
        chk("rst_raddr", 64'(o_csr_raddr), 64'd0);

        // read only
        mem[12'h305] = 32'h8000_0100; ref_mem[12'h305] = 32'h8000_0100;
        txn(12'h305, 1'b0, 12'h0, 32'h0, 1'b0, 12'h0, 32'h0, 0);
        // CSRRW-style
        mem[12'h341] = 32'hAA; ref_mem[12'h341] = 32'hAA;
        txn(12'h341, 1'b1, 12'h341, 32'h1234, 1'b0, 12'h0, 32'h0, 0);
        chk("csrrw_file", 64'(mem[12'h341]), 64'h1234);
        // ecall-style
        txn(12'h305, 1'b1, 12'h341, 32'h8000_0010, 1'b1, 12'h342, 32'h0b, 0);
        // equal addresses
        txn(12'h300, 1'b1, 12'h300, 32'h1, 1'b1, 12'h300, 32'h80, 0);
        chk("equal_addr_file", 64'(mem[12'h300]), 64'h80);
        // back-pressure for 5 cycles
        txn(12'h342, 1'b0, 12'h0, 32'h0, 1'b1, 12'h305, 32'hCAFE, 5);

        // reset while in WR1: first write lands, second is dropped
        mon_q.delete();
        i_raddr = 12'h300; i_wena1 = 1'b1; i_waddr1 = 12'h341; i_wdata1 = 32'h5151;
        i_wena2 = 1'b1; i_waddr2 = 12'h342; i_wdata2 = 32'h5252; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        chk("in_wr1_wen", 64'(o_csr_wen), 64'd1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        ref_mem[12'h341] = 32'h5151;
        chk("midrst_ready", 64'(o_ready), 64'd1);
        chk("midrst_valid", 64'(o_valid), 64'd0);
        chk("midrst_wen", 64'(o_csr_wen), 64'd0);
        chk("midrst_rdata", 64'(o_rdata), 64'd0);
        tick(); tick(); tick();
        chk("midrst_pulses", 64'(mon_q.size()), 64'd1);
        chk("midrst_file2", 64'(mem[12'h342]), 64'(ref_mem[12'h342]));

        for (int n = 0; n < 40; n++) begin
            txn(pick[$urandom_range(0, 3)],
                1'($urandom), pick[$urandom_range(0, 3)], $urandom,
                1'($urandom), pick[$urandom_range(0, 3)], $urandom,
                int'($urandom_range(0, 2)));
        end
        for (int k = 0; k < 4; k++)
            chk("final_file", 64'(mem[pick[k]]), 64'(ref_mem[pick[k]]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
